// File: rtl/ysyx_mem_arb_pkg.sv
// ysyx_mem_arb_pkg -- shared encodings for the ysyx memory arbiter.
//
// This file also acts as the shared ysyx_macro.v header: the ysyx_ARB_*
// macros below are the single source of truth for the 2-bit FSM state
// encoding and the 1-bit owner encoding. The package re-exports them as
// typed localparams so the RTL never uses raw literals.
//
// Optional feature macro used by the arbiter: YSYX_MEM_ARB_RR_EN
// (round-robin between IFU and LSU; fixed store > load > fetch otherwise).

`ifndef YSYX_MACRO_V
`define YSYX_MACRO_V
`define ysyx_ARB_IDLE     2'b00
`define ysyx_ARB_IFU_RD   2'b01
`define ysyx_ARB_LSU_RD   2'b10
`define ysyx_ARB_LSU_WR   2'b11
`define ysyx_ARB_OWN_IFU  1'b0
`define ysyx_ARB_OWN_LSU  1'b1
`endif

package ysyx_mem_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = `ysyx_ARB_IDLE;
    localparam logic [1:0] ST_IFU_RD = `ysyx_ARB_IFU_RD;
    localparam logic [1:0] ST_LSU_RD = `ysyx_ARB_LSU_RD;
    localparam logic [1:0] ST_LSU_WR = `ysyx_ARB_LSU_WR;

    // Owner encodings (which requester holds the bus / was granted last)
    localparam logic OWN_IFU = `ysyx_ARB_OWN_IFU;
    localparam logic OWN_LSU = `ysyx_ARB_OWN_LSU;

    // Fetches always read a full word
    localparam logic [7:0] FETCH_RSTRB = 8'h0f;

    // Result of one arbitration decision taken in IDLE
    typedef struct packed {
        logic       valid;
        logic [1:0] state;
    } grant_t;

    function automatic logic is_read_state(input logic [1:0] st);
        return (st == ST_IFU_RD) || (st == ST_LSU_RD);
    endfunction

    function automatic logic owner_of(input logic [1:0] st);
        return (st == ST_IFU_RD) ? OWN_IFU : OWN_LSU;
    endfunction

endpackage

// File: rtl/ysyx_mem_arb_pick.sv
// ysyx_mem_arb_pick -- combinational grant decision for ysyx_mem_arb.
//
// Store beats load inside the LSU. Between LSU and IFU the LSU wins by
// default; with YSYX_MEM_ARB_RR_EN defined, a contested grant goes to the
// requester that was not granted last.

module ysyx_mem_arb_pick
    import ysyx_mem_arb_pkg::*;
(
    input  logic   store_req,
    input  logic   load_req,
    input  logic   fetch_req,
`ifdef YSYX_MEM_ARB_RR_EN
    input  logic   last_grant,
`endif
    output grant_t grant
);

    logic       lsu_req;
    logic [1:0] lsu_state;
    logic       ifu_first;

    // Pick the winning requester and the state it moves the FSM to
    always_comb begin
        lsu_req   = store_req | load_req;
        lsu_state = store_req ? ST_LSU_WR : ST_LSU_RD;
        ifu_first = 1'b0;
`ifdef YSYX_MEM_ARB_RR_EN
        ifu_first = fetch_req & lsu_req & (last_grant == OWN_LSU);
`endif
        grant.valid = lsu_req | fetch_req;
        if (ifu_first) begin
            grant.state = ST_IFU_RD;
        end else if (lsu_req) begin
            grant.state = lsu_state;
        end else if (fetch_req) begin
            grant.state = ST_IFU_RD;
        end else begin
            grant.state = ST_IDLE;
        end
    end

endmodule

// File: rtl/ysyx_mem_arb.sv
// ysyx_mem_arb -- shares one read port and one write port between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
//
// Optional feature: define YSYX_MEM_ARB_RR_EN for IFU/LSU round-robin.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; arbitrate and capture the winner's request
// IFU_RD | fetch on the bus; wait for bus_rvalid, then back to IDLE
// LSU_RD | load on the bus; wait for bus_rvalid, then back to IDLE
// LSU_WR | store on the bus; wait for bus_wready, then back to IDLE
//
// Every transaction is followed by at least one IDLE cycle, there is no
// timeout, and requester valids are not looked at once a grant is made.

module ysyx_mem_arb
    import ysyx_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,

    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,

    output logic [ADDR_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    output logic [7:0]        bus_rstrb,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,

    output logic [ADDR_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [7:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    grant_t            grant;
    logic              grant_take;

    logic [ADDR_W-1:0] cap_addr;
    logic [7:0]        cap_rstrb;
    logic [DATA_W-1:0] cap_wdata;
    logic [7:0]        cap_wstrb;

`ifdef YSYX_MEM_ARB_RR_EN
    logic              last_grant;
`endif

    ysyx_mem_arb_pick u_pick (
        .store_req  (lsu_awvalid & lsu_wvalid),
        .load_req   (lsu_arvalid),
        .fetch_req  (ifu_arvalid),
`ifdef YSYX_MEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (grant)
    );

    assign grant_take = (state == ST_IDLE) && grant.valid;

    // Next state: leave IDLE on a grant, return on the bus response
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant.valid) state_nxt = grant.state;
            ST_IFU_RD: if (bus_rvalid)  state_nxt = ST_IDLE;
            ST_LSU_RD: if (bus_rvalid)  state_nxt = ST_IDLE;
            ST_LSU_WR: if (bus_wready)  state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // State register; a reset mid-transaction simply drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's request on the grant edge; bus outputs use only these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr  <= '0;
            cap_rstrb <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else if (grant_take) begin
            case (grant.state)
                ST_IFU_RD: begin
                    cap_addr  <= ifu_araddr;
                    cap_rstrb <= FETCH_RSTRB;
                end
                ST_LSU_RD: begin
                    cap_addr  <= lsu_araddr;
                    cap_rstrb <= lsu_rstrb;
                end
                ST_LSU_WR: begin
                    cap_addr  <= lsu_awaddr;
                    cap_wdata <= lsu_wdata;
                    cap_wstrb <= lsu_wstrb;
                end
                default: begin
                    cap_addr  <= cap_addr;
                end
            endcase
        end
    end

`ifdef YSYX_MEM_ARB_RR_EN
    // Remember who was granted last so a contested grant alternates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_IFU;
        end else if (grant_take) begin
            last_grant <= owner_of(grant.state);
        end
    end
`endif

    // Bus side: valids follow the state, payload comes from the capture registers
    assign bus_arvalid = is_read_state(state);
    assign bus_araddr  = cap_addr;
    assign bus_rstrb   = cap_rstrb;
    assign bus_awvalid = (state == ST_LSU_WR);
    assign bus_wvalid  = (state == ST_LSU_WR);
    assign bus_awaddr  = cap_addr;
    assign bus_wdata   = cap_wdata;
    assign bus_wstrb   = cap_wstrb;

    // Requester side: responses reach only the owner, data is zero unless valid
    assign ifu_rvalid  = (state == ST_IFU_RD) & bus_rvalid;
    assign lsu_rvalid  = (state == ST_LSU_RD) & bus_rvalid;
    assign lsu_wready  = (state == ST_LSU_WR) & bus_wready;
    assign ifu_rdata   = ifu_rvalid ? bus_rdata : '0;
    assign lsu_rdata   = lsu_rvalid ? bus_rdata : '0;

endmodule

// File: doc/ysyx_mem_arb.md
YSYX_MEM_ARB -- requirements
Module: ysyx_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have ports: clk  in  1  clock, single domain; reset is asynchronous and active-low.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: ifu_araddr in ADDR_W, ifu_arvalid in 1: fetch read request.
REQ-006 SHALL have ports: ifu_rdata out DATA_W, ifu_rvalid out 1: fetch read response.
REQ-007 SHALL have ports: lsu_araddr in ADDR_W, lsu_arvalid in 1, lsu_rstrb in 8: load request.
REQ-008 SHALL have ports: lsu_rdata out DATA_W, lsu_rvalid out 1: load response.
REQ-009 SHALL have ports: lsu_awaddr in ADDR_W, lsu_awvalid in 1, lsu_wdata in DATA_W, lsu_wstrb in 8, lsu_wvalid in 1: store request.
REQ-010 SHALL have ports: lsu_wready out 1: store completion.
REQ-011 SHALL have ports: bus_araddr out ADDR_W, bus_arvalid out 1, bus_rstrb out 8, bus_rdata in DATA_W, bus_rvalid in 1: shared read port.
REQ-012 SHALL have ports: bus_awaddr out ADDR_W, bus_awvalid out 1, bus_wdata out DATA_W, bus_wstrb out 8, bus_wvalid out 1, bus_wready in 1: shared write port.

Function
REQ-013 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR.
REQ-014 In IDLE, a store request SHALL be lsu_awvalid&lsu_wvalid, a load request lsu_arvalid, and a fetch request ifu_arvalid.
REQ-015 In IDLE, default priority SHALL be store > load > fetch; the winner moves the FSM to LSU_WR/LSU_RD/IFU_RD on the next edge.
REQ-016 On the grant edge, the winner's address, rstrb or wdata/wstrb SHALL be captured into registers; bus outputs come only from these registers.
REQ-017 bus_arvalid SHALL be 1 exactly while in IFU_RD or LSU_RD.
REQ-018 bus_awvalid and bus_wvalid SHALL be 1 exactly while in LSU_WR.
REQ-019 bus_rstrb SHALL be 8'hf for fetches and the captured lsu_rstrb for loads.
REQ-020 Request latency SHALL be one cycle: the bus valid rises the cycle after the request is seen in IDLE.
REQ-021 In a read state with bus_rvalid=1, the owner's rvalid SHALL be 1 in that same cycle, its rdata SHALL equal bus_rdata combinationally, and the FSM SHALL go to IDLE.
REQ-022 In LSU_WR with bus_wready=1, lsu_wready SHALL be 1 in that same cycle and the FSM SHALL go to IDLE.
REQ-023 Non-owner response outputs SHALL be 0; rdata outputs SHALL be 0 when the corresponding rvalid is 0.
REQ-024 bus_rvalid outside a read state and bus_wready outside LSU_WR SHALL be ignored.
REQ-025 Requests SHALL NOT be aborted: deasserting a requester valid mid-transaction has no effect until the response arrives.
REQ-026 At least one IDLE cycle SHALL occur between transactions (2-cycle minimum per access).
REQ-027 A transaction SHALL have no timeout; the FSM waits indefinitely for a response.

Reset
REQ-028 On rst_n low, immediately and asynchronously: FSM=IDLE, captured registers=0, last-grant=IFU, all outputs=0.
REQ-029 Reset mid-transaction SHALL drop the transaction with no response pulse; after release, arbitration restarts from IDLE.

Configuration
REQ-030 With YSYX_MEM_ARB_RR_EN defined, a 1-bit last-grant register SHALL track the last granted requester; when both IFU and LSU request in IDLE, the requester not granted last wins, and store>load still holds within LSU.
REQ-031 With YSYX_MEM_ARB_RR_EN undefined, there SHALL be no last-grant register and fixed priority (REQ-015) applies.

Structure
REQ-032 State encodings (2-bit) and the owner encoding (IFU/LSU) SHALL be defined in shared header ysyx_macro.v as ysyx_ARB_* macros.
REQ-033 The grant decision SHALL be in one combinational sub-module, ysyx_mem_arb_pick; everything else stays flat.

Verification
REQ-034 Fetch only: ifu_araddr=0x8000_0000, bus_rvalid after 3 cycles with 0x0000_0413 -> ifu_rvalid 1 cycle with rdata 0x0000_0413, lsu outputs 0.
REQ-035 Simultaneous fetch and load 0x8000_1000 rstrb=0x3, fixed priority -> LSU_RD first with bus_rstrb 0x3, then IFU_RD after one IDLE cycle.
REQ-036 Store and load together: awaddr 0x8000_2000, wdata 0xDEADBEEF, wstrb 0xf -> LSU_WR first; lsu_wready on bus_wready; the load follows.
REQ-037 With RR_EN, continuous IFU and LSU requests over 6 grants -> strict alternation; without RR_EN -> LSU wins all grants.
REQ-038 rst_n pulled low while in LSU_RD, then bus_rvalid=1 after release -> no lsu_rvalid, FSM IDLE, all bus valids 0.
REQ-039 bus_wready=1 during IFU_RD -> ignored; FSM stays IFU_RD; lsu_wready stays 0.
